tone_ce_gen: RTL and testbench



---
 rtl/piano_pkg.sv | 33 +++
 rtl/tone_ce_gen_if.sv | 31 +++
 rtl/key_sync_prio.sv | 42 ++++
 rtl/tone_ce_gen.sv | 115 +++++++++++
 tb/tb_tone_ce_gen.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/piano_pkg.sv
// piano_pkg: shared note constants, index/state types and the divider
// table function used by tone_ce_gen and its key front end.
package piano_pkg;

   localparam int NOTE_NUM = 8;

   typedef logic [2:0] note_idx_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } state_t;

   // C4..C5 white keys in milli-Hz
   localparam longint NOTE_FREQ_MHZ [NOTE_NUM] = '{
      261630, 293660, 329630, 349230,
      392000, 440000, 493880, 523250
   };

   // round(clk_hz / (steps * f)), with f held in milli-Hz
   function automatic longint note_div(
      input longint clk_hz,
      input longint steps,
      input int     idx
   );
      longint num;
      longint den;
      num = clk_hz * 64'sd1000;
      den = steps * NOTE_FREQ_MHZ[idx];
      return (2 * num + den) / (2 * den);
   endfunction

endpackage

// File: rtl/tone_ce_gen_if.sv
// tone_ce_gen_if: key/enable inputs and tick/note outputs of tone_ce_gen.
// master = key source / counter side, slave = tone_ce_gen.
interface tone_ce_gen_if;
   import piano_pkg::*;

   logic                EN;
   logic [NOTE_NUM-1:0] KEY;
   logic                CE;
   logic                PHASE_RST;
   logic                NOTE_ON;
   note_idx_t           NOTE_IDX;

   modport master (
      output EN,
      output KEY,
      input  CE,
      input  PHASE_RST,
      input  NOTE_ON,
      input  NOTE_IDX
   );

   modport slave (
      input  EN,
      input  KEY,
      output CE,
      output PHASE_RST,
      output NOTE_ON,
      output NOTE_IDX
   );

endinterface

// File: rtl/key_sync_prio.sv
// key_sync_prio: 2-flop key synchroniser, enable mask, lowest-bit-wins
// priority encoder. Ports: i_clk, i_rst, i_en, i_key -> o_sel_valid, o_sel.
module key_sync_prio
   import piano_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_en,
   input  logic [NOTE_NUM-1:0] i_key,
   output logic                o_sel_valid,
   output note_idx_t           o_sel
);

   logic [NOTE_NUM-1:0] r_s1;
   logic [NOTE_NUM-1:0] r_s2;
   logic [NOTE_NUM-1:0] w_masked;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= i_key;
         r_s2 <= r_s1;
      end
   end

   // EN is a level control, not synchronised, so it acts one edge sooner
   assign w_masked    = r_s2 & {NOTE_NUM{i_en}};
   assign o_sel_valid = |w_masked;

   // scanning downward lets the lowest set bit overwrite the rest
   always_comb begin
      o_sel = '0;
      for (int i = NOTE_NUM - 1; i >= 0; i--) begin
         if (w_masked[i]) begin
            o_sel = note_idx_t'(i);
         end
      end
   end

endmodule

// File: rtl/tone_ce_gen.sv
// tone_ce_gen: plays the highest-priority key as a CE tick at STEPS x the
// note frequency, with a PHASE_RST pulse on every note start or change.
// Ports: CLK, RST (sync, active-high), bus (slave modport of tone_ce_gen_if).
module tone_ce_gen
   import piano_pkg::*;
#(
   parameter int CLK_HZ = 50000000,
   parameter int STEPS  = 8,
   parameter int DIV_W  = 16
) (
   input  logic         CLK,
   input  logic         RST,
   tone_ce_gen_if.slave bus
);

   logic             w_sel_valid;
   note_idx_t        w_sel;
   logic [DIV_W-1:0] w_div [NOTE_NUM];
   logic [DIV_W-1:0] w_load_sel;
   logic [DIV_W-1:0] w_load_cur;

   state_t           r_state;
   state_t           w_state_nx;
   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] w_cnt_nx;
   logic             r_ce;
   logic             w_ce_nx;
   logic             r_pr;
   logic             w_pr_nx;
   logic             r_on;
   logic             w_on_nx;
   note_idx_t        r_idx;
   note_idx_t        w_idx_nx;

   key_sync_prio u_key (
      .i_clk      (CLK),
      .i_rst      (RST),
      .i_en       (bus.EN),
      .i_key      (bus.KEY),
      .o_sel_valid(w_sel_valid),
      .o_sel      (w_sel)
   );

   for (genvar g = 0; g < NOTE_NUM; g++) begin : g_div
      assign w_div[g] = DIV_W'(note_div(CLK_HZ, STEPS, g));
   end

   // counter runs DIV-1 .. 0, so a reload spans exactly DIV edges
   assign w_load_sel = w_div[w_sel] - DIV_W'(1);
   assign w_load_cur = w_div[r_idx] - DIV_W'(1);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_ce    <= 1'b0;
         r_pr    <= 1'b0;
         r_on    <= 1'b0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_ce    <= w_ce_nx;
         r_pr    <= w_pr_nx;
         r_on    <= w_on_nx;
         r_idx   <= w_idx_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_ce_nx    = 1'b0;
      w_pr_nx    = 1'b0;
      w_on_nx    = r_on;
      w_idx_nx   = r_idx;
      unique case (r_state)
         ST_IDLE: begin
            w_on_nx  = 1'b0;
            w_cnt_nx = '0;
            if (w_sel_valid) begin
               w_state_nx = ST_PLAY;
               w_idx_nx   = w_sel;
               w_cnt_nx   = w_load_sel;
               w_on_nx    = 1'b1;
               w_pr_nx    = 1'b1;
            end
         end
         ST_PLAY: begin
            if (!w_sel_valid) begin
               w_state_nx = ST_IDLE;
               w_on_nx    = 1'b0;
               w_cnt_nx   = '0;
            end else if (w_sel != r_idx) begin
               // a change wins over a due tick: CE and
               // PHASE_RST must never coincide
               w_idx_nx = w_sel;
               w_cnt_nx = w_load_sel;
               w_pr_nx  = 1'b1;
            end else if (r_cnt == '0) begin
               w_ce_nx  = 1'b1;
               w_cnt_nx = w_load_cur;
            end else begin
               w_cnt_nx = r_cnt - DIV_W'(1);
            end
         end
      endcase
   end

   assign bus.CE        = r_ce;
   assign bus.PHASE_RST = r_pr;
   assign bus.NOTE_ON   = r_on;
   assign bus.NOTE_IDX  = r_idx;

endmodule

// File: tb/tb_tone_ce_gen.sv
// tb_tone_ce_gen: vector table, directed timing sequences and random
// key traffic against a note-phase reference model.
module tb_tone_ce_gen;

   localparam int TB_CLK_HZ = 500000;

   logic clk = 1'b0;
   logic rst;

   tone_ce_gen_if bus ();

   tone_ce_gen #(
      .CLK_HZ(TB_CLK_HZ),
      .STEPS (8),
      .DIV_W (16)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] key;
      logic       en;
      logic       on;
      int         idx;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int n_ce  = 0;
   int D [8];
   int MAXD;

   // reference: key delay line plus "cycles since note start" phase
   logic [7:0] m_k1, m_k2;
   bit         m_on, m_ce, m_pr;
   int         m_idx, m_ph;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      logic [7:0] mk;
      int s;
      if (rst) begin
         m_k1 = '0; m_k2 = '0; m_on = 0; m_ce = 0;
         m_pr = 0; m_idx = 0; m_ph = 0;
      end else begin
         mk = m_k2 & {8{bus.EN}};
         s = -1;
         for (int i = 0; i < 8; i++)
            if (mk[i] && s < 0) s = i;
         m_ce = 0;
         m_pr = 0;
         if (s < 0) begin
            m_on = 0;
            m_ph = 0;
         end else if (!m_on || s != m_idx) begin
            m_on = 1; m_idx = s; m_ph = 0; m_pr = 1;
         end else begin
            m_ph++;
            m_ce = (m_ph % D[m_idx]) == 0;
         end
         m_k2 = m_k1;
         m_k1 = bus.KEY;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_step();
      @(negedge clk);
      if (bus.CE) n_ce++;
      chk("model", int'({bus.NOTE_ON, bus.NOTE_IDX, bus.CE, bus.PHASE_RST}),
          int'({m_on, m_idx[2:0], m_ce, m_pr}));
      chk("ce_pr_excl", int'(bus.CE & bus.PHASE_RST), 0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_ce(input string nm, input int t_ref,
                          input int exp_dt, output int t_ce);
      int k;
      k = 0;
      t_ce = -1;
      do begin
         tick();
         k++;
      end while (!bus.CE && k < 4 * MAXD);
      if (bus.CE) t_ce = cyc;
      chk(nm, t_ce - t_ref, exp_dt);
   endtask

   initial begin
      vec_t tbl [12];
      real  f [8];
      int   spec_div [8];
      int   t0, t1, nce0;
      logic [7:0] k8;

      f = '{261.63, 293.66, 329.63, 349.23, 392.0, 440.0, 493.88, 523.25};
      spec_div = '{23889, 21283, 18961, 17897, 15944, 14205, 12655, 11945};
      MAXD = 0;
      for (int i = 0; i < 8; i++) begin
         D[i] = $rtoi(real'(TB_CLK_HZ) / (8.0 * f[i]) + 0.5);
         if (D[i] > MAXD) MAXD = D[i];
         chk("div_table_50M",
             int'(piano_pkg::note_div(50000000, 8, i)), spec_div[i]);
      end

      tbl[0]  = '{8'h01, 1'b1, 1'b1, 0};
      tbl[1]  = '{8'h02, 1'b1, 1'b1, 1};
      tbl[2]  = '{8'h04, 1'b1, 1'b1, 2};
      tbl[3]  = '{8'h08, 1'b1, 1'b1, 3};
      tbl[4]  = '{8'h10, 1'b1, 1'b1, 4};
      tbl[5]  = '{8'h20, 1'b1, 1'b1, 5};
      tbl[6]  = '{8'h40, 1'b1, 1'b1, 6};
      tbl[7]  = '{8'h80, 1'b1, 1'b1, 7};
      tbl[8]  = '{8'h90, 1'b1, 1'b1, 4};
      tbl[9]  = '{8'hFF, 1'b1, 1'b1, 0};
      tbl[10] = '{8'h60, 1'b1, 1'b1, 5};
      tbl[11] = '{8'h01, 1'b0, 1'b0, 0};

      // reset with every key held
      rst = 1'b1;
      bus.EN = 1'b1;
      bus.KEY = 8'hFF;
      ticks(4);
      chk("rst_outs", int'({bus.NOTE_ON, bus.NOTE_IDX, bus.CE,
                            bus.PHASE_RST}), 0);
      rst = 1'b0;
      ticks(2);
      chk("post_rst_on", int'(bus.NOTE_ON), 0);
      chk("post_rst_pr", int'(bus.PHASE_RST), 0);
      tick();
      chk("post_rst_play", int'({bus.NOTE_ON, bus.PHASE_RST}), 3);
      bus.KEY = '0;
      ticks(4);

      // priority vectors, each from idle
      for (int v = 0; v < 12; v++) begin
         bus.KEY = tbl[v].key;
         bus.EN = tbl[v].en;
         ticks(3);
         chk("vec_on", int'(bus.NOTE_ON), int'(tbl[v].on));
         chk("vec_pr", int'(bus.PHASE_RST), int'(tbl[v].on));
         if (tbl[v].on) chk("vec_idx", int'(bus.NOTE_IDX), tbl[v].idx);
         bus.KEY = '0;
         bus.EN = 1'b1;
         ticks(4);
      end

      // A4: CE at +D, +2D, +3D from NOTE_ON rise
      bus.KEY = 8'h20;
      ticks(3);
      chk("a4_idx", int'(bus.NOTE_IDX), 5);
      t0 = cyc;
      wait_ce("a4_ce1", t0, D[5], t1);
      wait_ce("a4_ce2", t0, 2 * D[5], t1);
      wait_ce("a4_ce3", t0, 3 * D[5], t1);

      // priority, then release of the higher key
      bus.KEY = 8'h90;
      ticks(3);
      chk("g4_idx", int'(bus.NOTE_IDX), 4);
      chk("g4_pr", int'(bus.PHASE_RST), 1);
      t0 = cyc;
      wait_ce("g4_ce1", t0, D[4], t1);
      wait_ce("g4_per", t1, D[4], t0);
      bus.KEY = 8'h80;
      ticks(3);
      chk("c5_idx", int'(bus.NOTE_IDX), 7);
      chk("c5_pr_ce", int'({bus.PHASE_RST, bus.CE}), 2);
      t0 = cyc;
      wait_ce("c5_ce1", t0, D[7], t1);

      // note change landing on the cnt==0 edge
      bus.KEY = '0;
      ticks(4);
      bus.KEY = 8'h01;
      ticks(3);
      t0 = cyc;
      while (cyc < t0 + D[0] - 3) tick();
      bus.KEY = 8'h02;
      ticks(3);
      chk("coin_cyc", cyc - t0, D[0]);
      chk("coin_pr_ce", int'({bus.PHASE_RST, bus.CE}), 2);
      chk("coin_idx", int'(bus.NOTE_IDX), 1);
      t0 = cyc;
      wait_ce("coin_ce", t0, D[1], t1);

      // release mid-period, then EN gating
      ticks(D[1] / 2);
      bus.KEY = '0;
      ticks(2);
      chk("rel_on_hold", int'(bus.NOTE_ON), 1);
      tick();
      chk("rel_on_fall", int'(bus.NOTE_ON), 0);
      nce0 = n_ce;
      ticks(2 * D[1]);
      chk("rel_no_ce", n_ce - nce0, 0);
      bus.EN = 1'b0;
      bus.KEY = 8'h01;
      ticks(6);
      chk("en0_quiet", int'({bus.NOTE_ON, bus.PHASE_RST}), 0);
      chk("en0_no_ce", n_ce - nce0, 0);
      bus.EN = 1'b1;
      tick();
      chk("en1_play", int'({bus.NOTE_ON, bus.PHASE_RST}), 3);
      chk("en1_idx", int'(bus.NOTE_IDX), 0);

      // reset while playing C5
      bus.KEY = 8'h80;
      ticks(3);
      chk("mid_idx", int'(bus.NOTE_IDX), 7);
      ticks(40);
      rst = 1'b1;
      tick();
      chk("mid_rst", int'({bus.NOTE_ON, bus.NOTE_IDX, bus.CE,
                           bus.PHASE_RST}), 0);
      rst = 1'b0;
      ticks(2);
      chk("mid_rst_wait", int'(bus.NOTE_ON), 0);
      tick();
      chk("mid_replay", int'({bus.NOTE_ON, bus.PHASE_RST}), 3);
      chk("mid_replay_idx", int'(bus.NOTE_IDX), 7);

      // random key traffic
      for (int s = 0; s < 40; s++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 2) k8 = '0;
         else if (r < 7) k8 = 8'h01 << $urandom_range(0, 7);
         else k8 = 8'($urandom);
         bus.KEY = k8;
         bus.EN = ($urandom_range(0, 7) != 0);
         rst = ($urandom_range(0, 19) == 0);
         tick();
         rst = 1'b0;
         ticks(int'($urandom_range(1, 300)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
